// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;
  localparam int unsigned HILO_ITER  = HILO_WIDTH;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative core: unsigned shift-add multiply or restoring divide,
// one step per cycle on a 2*WIDTH accumulator.
module muldiv_iter_core
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH,
  parameter int unsigned ITER  = HILO_ITER
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int unsigned CNT_W = cnt_width(ITER);

  logic [WIDTH-1:0]   operand;
  logic               div_mode;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;

  // Multiply: {partial, multiplier} shifts right, carry kept in mul_sum MSB.
  // Divide: {remainder, dividend} shifts left, quotient bits enter at bit 0.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, operand};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      if (!div_diff[WIDTH]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      operand  <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= {{WIDTH{1'b0}}, a_in};
      operand  <= b_in;
      div_mode <= is_div;
      cnt      <= '0;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(ITER - 1));

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage HI/LO owner: sequences multi-cycle mul/div, applies sign fix-up,
// MADD/MSUB accumulation, and requests pipeline stalls while busy.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  input  logic             Flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Stall
);

  state_e             state;
  op_e                op_in;
  op_e                op_q;
  logic               res_sign;
  logic               rem_sign;
  logic               div_zero_q;
  logic               accept;
  logic               is_mul_op;
  logic               is_div_op;
  logic               is_signed_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               core_load;
  logic               core_step;
  logic               core_last;
  logic [2*WIDTH-1:0] core_acc;
  logic [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0] hilo_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_in        = op_e'(Op);
  assign is_mul_op    = op_in inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
  assign is_div_op    = op_in inside {OP_DIV, OP_DIVU};
  assign is_signed_op = op_in inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  assign mag_a        = (is_signed_op && A[WIDTH-1]) ? -A : A;
  assign mag_b        = (is_signed_op && B[WIDTH-1]) ? -B : B;

  assign Busy  = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
  assign Stall = Busy & (Start | HiLoRead);

  // A new op may enter from IDLE or in the DONE cycle; Flush always wins.
  assign accept    = Start && !Flush && ((state == ST_IDLE) || (state == ST_DONE));
  assign core_load = accept && (is_mul_op || is_div_op);
  assign core_step = ((state == ST_MUL) || (state == ST_DIV)) && !Flush;

  muldiv_iter_core #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_core (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div_op),
    .a_in   (mag_a),
    .b_in   (mag_b),
    .acc    (core_acc),
    .last   (core_last)
  );

  // Divide-by-zero: the core naturally yields remainder |A| (sign-fixed back
  // to A) and an all-ones quotient magnitude; only LO needs overriding.
  always_comb begin
    prod_signed = res_sign ? -core_acc : core_acc;
    quot        = core_acc[WIDTH-1:0];
    rem         = core_acc[2*WIDTH-1:WIDTH];
    quot_fix    = div_zero_q ? '1 : (res_sign ? -quot : quot);
    rem_fix     = rem_sign ? -rem : rem;
    case (op_q)
      OP_MADD:         hilo_fix = {HI, LO} + prod_signed;
      OP_MSUB:         hilo_fix = {HI, LO} - prod_signed;
      OP_DIV, OP_DIVU: hilo_fix = {rem_fix, quot_fix};
      default:         hilo_fix = prod_signed;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      HI         <= '0;
      LO         <= '0;
      Done       <= 1'b0;
      DivZero    <= 1'b0;
      op_q       <= OP_MULT;
      res_sign   <= 1'b0;
      rem_sign   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept) begin
            DivZero    <= 1'b0;
            op_q       <= op_in;
            res_sign   <= is_signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            rem_sign   <= is_signed_op & A[WIDTH-1];
            div_zero_q <= is_div_op && (B == '0);
            case (op_in)
              OP_MTHI:         HI <= A;
              OP_MTLO:         LO <= A;
              OP_DIV, OP_DIVU: state <= ST_DIV;
              default:         state <= ST_MUL;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else if (core_last) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else begin
            {HI, LO} <= hilo_fix;
            Done     <= 1'b1;
            DivZero  <= div_zero_q;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
